// File: rtl/boot_jtag_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, default opcodes, IR capture pattern
// and the TMS-driven next-state function used by boot_jtag_tap_fsm.
package boot_jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SEL_IR     = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SEL_DR     = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RTI        = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TLR        = 4'hF
    } tap_state_e;

    localparam logic [3:0] OP_IDCODE_DEF = 4'h1;
    localparam logic [3:0] OP_USER_DEF   = 4'h2;
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;
    localparam int         IDCODE_W = 32;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            TLR:        n = tms ? TLR       : RTI;
            RTI:        n = tms ? SEL_DR    : RTI;
            SEL_DR:     n = tms ? SEL_IR    : CAPTURE_DR;
            CAPTURE_DR: n = tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   n = tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   n = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   n = tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   n = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  n = tms ? SEL_DR    : RTI;
            SEL_IR:     n = tms ? TLR       : CAPTURE_IR;
            CAPTURE_IR: n = tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   n = tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   n = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   n = tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   n = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  n = tms ? SEL_DR    : RTI;
            default:    n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/boot_jtag_tap_fsm.sv
// TAP state register plus per-state strobes; tlr_next flags any transition landing
// in Test-Logic-Reset so the IR can be reloaded on that same edge.
module boot_jtag_tap_fsm
    import boot_jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trstn,
    input  logic       tms,
    output tap_state_e state,
    output logic       tlr_next,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) state_q <= TLR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = tap_next(state_q, tms);
        tlr_next   = (state_d == TLR);
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        case (state_q)
            CAPTURE_DR: capture_dr = 1'b1;
            SHIFT_DR:   shift_dr   = 1'b1;
            UPDATE_DR:  update_dr  = 1'b1;
            CAPTURE_IR: capture_ir = 1'b1;
            SHIFT_IR:   shift_ir   = 1'b1;
            UPDATE_IR:  update_ir  = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/boot_jtag_tap.sv
// Fabric-side 1149.1 TAP: IR, BYPASS, optional IDCODE and a USER DR with parallel
// capture/update. Define BOOT_JTAG_IDCODE_EN to include the IDCODE register.
module boot_jtag_tap
    import boot_jtag_pkg::*;
#(
    parameter int              IR_W       = 4,
    parameter int              DR_W       = 32,
    parameter logic [31:0]     IDCODE_VAL = 32'h1000_563F,
    parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(OP_IDCODE_DEF),
    parameter logic [IR_W-1:0] OP_USER    = IR_W'(OP_USER_DEF)
) (
    input  logic            BOOT_JTAG_TCK,
    input  logic            BOOT_JTAG_TRSTN,
    input  logic            BOOT_JTAG_TMS,
    input  logic            BOOT_JTAG_TDI,
    output logic            BOOT_JTAG_TDO,
    output logic            BOOT_JTAG_TDO_OE,
    input  logic [DR_W-1:0] USER_DR_IN,
    output logic [DR_W-1:0] USER_DR_OUT,
    output logic            USER_DR_UPDATE,
    output logic [IR_W-1:0] IR_OUT,
    output logic [3:0]      TAP_STATE
);

`ifdef BOOT_JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RST = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RST = '1;
`endif
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(IR_CAPTURE_LSBS);

    if (IDCODE_VAL[0] != 1'b1 || OP_IDCODE == OP_USER) begin : g_bad_cfg
        $error("boot_jtag_tap: IDCODE_VAL[0] must be 1 and opcodes must differ");
    end

    wire tck   = BOOT_JTAG_TCK;
    wire trstn = BOOT_JTAG_TRSTN;
    wire tdi   = BOOT_JTAG_TDI;

    tap_state_e state;
    logic tlr_next, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

    boot_jtag_tap_fsm u_fsm (
        .tck        (tck),
        .trstn      (trstn),
        .tms        (BOOT_JTAG_TMS),
        .state      (state),
        .tlr_next   (tlr_next),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir)
    );

    logic [IR_W-1:0] ir_shift, ir_q;
    logic [DR_W-1:0] user_shift;
    logic            bypass_q;
    logic            sel_user, sel_idcode, dr_lsb;

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            ir_shift <= '0;
            ir_q     <= IR_RST;
        end else begin
            if (capture_ir)    ir_shift <= IR_CAPTURE;
            else if (shift_ir) ir_shift <= {tdi, ir_shift[IR_W-1:1]};
            if (tlr_next)       ir_q <= IR_RST;
            else if (update_ir) ir_q <= ir_shift;
        end
    end

    // Shift form below stays legal for a one-bit USER register.
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            user_shift <= '0;
            bypass_q   <= 1'b0;
        end else begin
            if (capture_dr && sel_user)    user_shift <= USER_DR_IN;
            else if (shift_dr && sel_user) user_shift <= (user_shift >> 1) | (DR_W'(tdi) << (DR_W - 1));
            if (capture_dr)    bypass_q <= 1'b0;
            else if (shift_dr) bypass_q <= tdi;
        end
    end

`ifdef BOOT_JTAG_IDCODE_EN
    logic [IDCODE_W-1:0] id_shift;

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn)                      id_shift <= '0;
        else if (capture_dr && sel_idcode) id_shift <= IDCODE_VAL;
        else if (shift_dr && sel_idcode)   id_shift <= {tdi, id_shift[IDCODE_W-1:1]};
    end

    assign sel_idcode = (ir_q == OP_IDCODE);
`else
    assign sel_idcode = 1'b0;
`endif

    assign sel_user = (ir_q == OP_USER);

    always_comb begin
        dr_lsb = bypass_q;
        if (sel_user) dr_lsb = user_shift[0];
`ifdef BOOT_JTAG_IDCODE_EN
        else if (sel_idcode) dr_lsb = id_shift[0];
`endif
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            USER_DR_OUT    <= '0;
            USER_DR_UPDATE <= 1'b0;
        end else begin
            USER_DR_UPDATE <= update_dr && sel_user;
            if (update_dr && sel_user) USER_DR_OUT <= user_shift;
        end
    end

    // TDO launches on the falling edge so the host samples it cleanly on the next rise.
    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            BOOT_JTAG_TDO    <= 1'b0;
            BOOT_JTAG_TDO_OE <= 1'b0;
        end else begin
            BOOT_JTAG_TDO_OE <= shift_ir || shift_dr;
            BOOT_JTAG_TDO    <= shift_ir ? ir_shift[0] : (shift_dr ? dr_lsb : 1'b0);
        end
    end

    assign IR_OUT    = ir_q;
    assign TAP_STATE = state;

endmodule

// File: tb/tb_boot_jtag_tap.sv
// Scoreboard bench for boot_jtag_tap: scan tasks derive expected TDO streams and
// USER updates from a bit-stream view of each scan; a monitor pops and compares.
module tb_boot_jtag_tap;

    localparam logic [3:0]  ST_TLR = 4'hF;
    localparam logic [3:0]  ST_RTI = 4'hC;
    localparam logic [3:0]  OP_ID  = 4'h1;
    localparam logic [3:0]  OP_USR = 4'h2;
    localparam logic [31:0] IDV    = 32'h1000_563F;
`ifdef BOOT_JTAG_IDCODE_EN
    localparam logic [3:0]  IR_RST = 4'h1;
    localparam bit          ID_EN  = 1'b1;
`else
    localparam logic [3:0]  IR_RST = 4'hF;
    localparam bit          ID_EN  = 1'b0;
`endif

    logic        tck = 1'b0;
    logic        TRSTN, TMS, TDI;
    logic        TDO, TDO_OE, UPD;
    logic [31:0] UIN, UOUT;
    logic [3:0]  IR, STATE;

    boot_jtag_tap dut (
        .BOOT_JTAG_TCK    (tck),
        .BOOT_JTAG_TRSTN  (TRSTN),
        .BOOT_JTAG_TMS    (TMS),
        .BOOT_JTAG_TDI    (TDI),
        .BOOT_JTAG_TDO    (TDO),
        .BOOT_JTAG_TDO_OE (TDO_OE),
        .USER_DR_IN       (UIN),
        .USER_DR_OUT      (UOUT),
        .USER_DR_UPDATE   (UPD),
        .IR_OUT           (IR),
        .TAP_STATE        (STATE)
    );

    initial forever #5 tck = ~tck;

    int checks = 0, failures = 0;
    int mon_checks = 0, mon_fails = 0;
    logic        exp_tdo[$];
    logic [31:0] exp_upd[$];
    logic [3:0]  m_ir;
    logic [31:0] m_uout;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: TDO is sampled on the rising edge, the update strobe on the falling edge.
    initial begin
        logic        eb;
        logic [31:0] ev;
        forever begin
            @(posedge tck);
            if (TDO_OE === 1'b1) begin
                mon_checks++;
                if (exp_tdo.size() == 0) begin
                    mon_fails++;
                    $display("FAIL tdo_unexpected: got %b with no bit expected", TDO);
                end else begin
                    eb = exp_tdo.pop_front();
                    if (TDO !== eb) begin
                        mon_fails++;
                        $display("FAIL tdo_bit: got %b expected %b", TDO, eb);
                    end
                end
            end
            @(negedge tck);
            if (UPD !== 1'b0) begin
                mon_checks++;
                if (exp_upd.size() == 0) begin
                    mon_fails++;
                    $display("FAIL update_unexpected: strobe=%b out=%h", UPD, UOUT);
                end else begin
                    ev = exp_upd.pop_front();
                    if (UOUT !== ev) begin
                        mon_fails++;
                        $display("FAIL user_update: got %h expected %h", UOUT, ev);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge tck);
        #1;
    endtask

    // Capture length and value of the data register selected by the model's IR.
    task automatic dr_sel(output int len, output logic [63:0] cap);
        if (m_ir == OP_USR) begin
            len = 32; cap = 64'(UIN);
        end else if (ID_EN && m_ir == OP_ID) begin
            len = 32; cap = 64'(IDV);
        end else begin
            len = 1;  cap = 64'd0;
        end
    endtask

    task automatic tap_reset_tms();
        repeat (5) step(1'b1, 1'b0);
        m_ir = IR_RST;
        check("tms_reset_state", 64'(STATE), 64'(ST_TLR));
        check("tms_reset_ir", 64'(IR), 64'(m_ir));
        check("tms_reset_uout_kept", 64'(UOUT), 64'(m_uout));
    endtask

    // Scan n bits of tdi_bits (LSB first); pause_at>0 detours through Pause after that many shifts.
    task automatic scan(input bit is_ir, input logic [63:0] tdi_bits, input int n, input int pause_at);
        int          len;
        logic [63:0] cap, reg_v;
        logic        s[$];
        if (is_ir) begin
            len = 4; cap = 64'd1;
        end else begin
            dr_sel(len, cap);
        end
        s = {};
        for (int i = 0; i < len; i++) s.push_back(cap[i]);
        for (int i = 0; i < n; i++)   s.push_back(tdi_bits[i]);
        for (int i = 0; i < n; i++)   exp_tdo.push_back(s[i]);
        reg_v = '0;
        for (int i = 0; i < len; i++) reg_v[i] = s[n + i];

        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        if (is_ir) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        if (n == 0) begin
            step(1'b1, 1'b0);
        end else begin
            step(1'b0, 1'b0);
            for (int i = 0; i < n; i++) begin
                step((i == n - 1) || (i + 1 == pause_at), tdi_bits[i]);
                if (i + 1 == pause_at && i != n - 1) begin
                    repeat (3) step(1'b0, 1'b0);
                    step(1'b1, 1'b0);
                    step(1'b0, 1'b0);
                end
            end
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        if (is_ir) begin
            m_ir = reg_v[3:0];
        end else if (m_ir == OP_USR) begin
            m_uout = reg_v[31:0];
            exp_upd.push_back(m_uout);
        end
        check("scan_end_state", 64'(STATE), 64'(ST_RTI));
        check("scan_ir", 64'(IR), 64'(m_ir));
        check("scan_uout", 64'(UOUT), 64'(m_uout));
    endtask

    initial begin
        int          len, n, pa;
        logic [63:0] cap;
        logic [3:0]  op;
        TRSTN = 1'b0; TMS = 1'b1; TDI = 1'b0; UIN = 32'h0;
        m_ir = IR_RST; m_uout = 32'h0;
        #23;
        check("rst_state", 64'(STATE), 64'(ST_TLR));
        check("rst_ir", 64'(IR), 64'(IR_RST));
        check("rst_tdo", 64'(TDO), 64'd0);
        check("rst_oe", 64'(TDO_OE), 64'd0);
        check("rst_uout", 64'(UOUT), 64'd0);
        check("rst_upd", 64'(UPD), 64'd0);
        @(negedge tck); #2 TRSTN = 1'b1;

        // Enter Shift-DR then leave via five TMS=1; one captured bit is seen on the way.
        dr_sel(len, cap);
        exp_tdo.push_back(cap[0]);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        tap_reset_tms();
        check("tms_reset_oe", 64'(TDO_OE), 64'd0);

        // First DR scan after reset: IDCODE or one bypass bit followed by TDI.
        scan(1'b0, {$urandom, $urandom}, 32, -1);

        // IR scan of 4'hF, then bypass: TDI 1,0,1,1,1 gives TDO 0,1,0,1,1.
        scan(1'b1, 64'hF, 4, -1);
        scan(1'b0, 64'b11101, 5, -1);

        // USER register round trip.
        scan(1'b1, 64'(OP_USR), 4, -1);
        UIN = 32'h1234_5678;
        scan(1'b0, 64'hA5A5_5A5A, 32, -1);

        // Shift interrupted by Pause x3, and Capture straight to Update with no shift.
        UIN = $urandom;
        scan(1'b0, {$urandom, $urandom}, 40, 13);
        UIN = $urandom;
        scan(1'b0, 64'd0, 0, -1);

        // TRSTN pulse after 10 USER shift bits.
        UIN = $urandom;
        for (int i = 0; i < 10; i++) exp_tdo.push_back(UIN[i]);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom));
        #2 TRSTN = 1'b0;
        #1;
        check("abort_state", 64'(STATE), 64'(ST_TLR));
        check("abort_tdo", 64'(TDO), 64'd0);
        check("abort_oe", 64'(TDO_OE), 64'd0);
        check("abort_uout", 64'(UOUT), 64'd0);
        check("abort_ir", 64'(IR), 64'(IR_RST));
        m_ir = IR_RST; m_uout = 32'h0;
        @(negedge tck); #2 TRSTN = 1'b1;

        // Randomised mix of IR scans, DR scans (with and without pause) and TMS resets.
        for (int it = 0; it < 30; it++) begin
            UIN = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    case ($urandom_range(0, 3))
                        0:       op = OP_ID;
                        1:       op = OP_USR;
                        2:       op = 4'hF;
                        default: op = 4'($urandom_range(0, 15));
                    endcase
                    pa = $urandom_range(0, 1) ? 2 : -1;
                    scan(1'b1, 64'(op), 4, pa);
                end
                3: tap_reset_tms();
                default: begin
                    n  = $urandom_range(0, 48);
                    pa = (n > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
                    scan(1'b0, {$urandom, $urandom}, n, pa);
                end
            endcase
        end

        repeat (3) step(1'b0, 1'b0);
        check("tdo_queue_drained", 64'(exp_tdo.size()), 64'd0);
        check("update_queue_drained", 64'(exp_upd.size()), 64'd0);
        checks   += mon_checks;
        failures += mon_fails;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
